// File: rtl/alu_pkg.sv
// Shared definitions for the 1-bit ALU slice and the bit-serial sequencer:
// operation codes, control-field positions and sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    localparam int AINV   = 3;
    localparam int BNEG   = 2;
    localparam int OP_MSB = 1;
    localparam int OP_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic ctl_legal(input logic [3:0] c);
        return (c == CTL_AND) || (c == CTL_OR) || (c == CTL_ADD) ||
               (c == CTL_SUB) || (c == CTL_SLT) || (c == CTL_NOR);
    endfunction

    function automatic logic ctl_arith(input logic [3:0] c);
        return (c == CTL_ADD) || (c == CTL_SUB) || (c == CTL_SLT);
    endfunction

endpackage

// File: rtl/ALU.sv
// 1-bit ALU slice: optional inversion of either input, then AND/OR/sum/less
// selected by the low two control bits; carry is always produced.
module ALU
    import alu_pkg::*;
(
    input  logic [3:0] ALUctl,
    input  logic       a,
    input  logic       b,
    input  logic       c_in,
    input  logic       slt,
    output logic       ALUout,
    output logic       c_out
);

    logic a_eff;
    logic b_eff;

    assign a_eff = a ^ ALUctl[AINV];
    assign b_eff = b ^ ALUctl[BNEG];
    assign c_out = (a_eff & b_eff) | (a_eff & c_in) | (b_eff & c_in);

    always_comb begin
        ALUout = slt;
        case (ALUctl[OP_MSB:OP_LSB])
            2'b00:   ALUout = a_eff & b_eff;
            2'b01:   ALUout = a_eff | b_eff;
            2'b10:   ALUout = a_eff ^ b_eff ^ c_in;
            default: ALUout = slt;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Multi-cycle ALU: drives one ALU slice LSB first, one bit per clock, with the
// carry fed back through a register; start/done handshake to the datapath.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; outputs hold the last result
// ST_RUN  | one operand bit per cycle through the slice, LSB first
// ST_DONE | finalise result (SLT fix-up, illegal codes), pulse done
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [3:0]       ctl_q;
    logic             carry_q;
    logic [CW-1:0]    idx;
    logic             cout_q;
    logic             ovf_q;
    logic             msb_q;

    logic             accept;
    logic             last_bit;
    logic [3:0]       slice_ctl;
    logic             slice_out;
    logic             slice_cout;
    logic [WIDTH-1:0] final_res;
    logic             final_cout;

    // SLT runs through the slice as a subtract; the sign fix-up happens in DONE.
    assign slice_ctl = (ctl_q == CTL_SLT) ? CTL_SUB : ctl_q;
    assign last_bit  = (idx == CW'(WIDTH - 1));

    ALU u_slice (
        .ALUctl (slice_ctl),
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .c_in   (carry_q),
        .slt    (1'b0),
        .ALUout (slice_out),
        .c_out  (slice_cout)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:  if (last_bit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        final_res  = res_sr;
        final_cout = ctl_arith(ctl_q) ? cout_q : 1'b0;
        if (!ctl_legal(ctl_q)) begin
            final_res  = '0;
            final_cout = 1'b0;
        end else if (ctl_q == CTL_SLT) begin
            final_res = {{(WIDTH-1){1'b0}}, msb_q ^ ovf_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            result    <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            ctl_q     <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            msb_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == ST_DONE);
            busy  <= accept || (state != ST_IDLE);
            zero  <= (result == '0);

            if (accept) begin
                a_sr    <= a;
                b_sr    <= b;
                ctl_q   <= ctl;
                carry_q <= ctl[BNEG];
                idx     <= '0;
                res_sr  <= '0;
            end

            // Operands shift right so bit i is always at position 0.
            if (state == ST_RUN) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                res_sr  <= {slice_out, res_sr[WIDTH-1:1]};
                carry_q <= slice_cout;
                idx     <= idx + 1'b1;
                if (last_bit) begin
                    cout_q <= slice_cout;
                    ovf_q  <= carry_q ^ slice_cout;
                    msb_q  <= slice_out;
                end
            end

            if (state == ST_DONE) begin
                result    <= final_res;
                carry_out <= final_cout;
                zero      <= (final_res == '0);
            end
        end
    end

endmodule
